serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequencer that computes a W-bit sum (a + b + cin) with a single 4-bit adder slice.
- The slice is time-shared across nibbles, one nibble per clock, least-significant nibble first.
- A carry register links successive nibbles.
- Start/busy/done handshake to the surrounding datapath; the result is held stable until the next accepted operation.

Parameters:
- W, 16, operand width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise).
- NIB, W/4, derived nibble count; not overridable.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- abort  input  1  cancels operation in RUN
- a  input  W  operand A, captured on accepted start
- b  input  W  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result updates
- sum  output  W  last completed sum
- cout  output  1  last completed carry-out

Interface (already decided): one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, sum=0, cout=0; operand regs, working reg, carry reg and index all 0.
- States: IDLE, RUN, DONE (encoded in the package enum).
- IDLE:
  - start=1 at edge: capture a, b, cin into operand regs, carry_reg<=cin, idx<=0, go RUN.
  - Otherwise stay.
- RUN, each edge:
  - Slice inputs: opA[4*idx+:4], opB[4*idx+:4], carry_reg.
  - Slice sum nibble is written to work[4*idx+:4]; carry_reg<=slice cout; idx<=idx+1.
  - When idx==NIB-1 at the edge: sum<=work with the final nibble merged in, cout<=slice cout, done<=1, go DONE.
- DONE (one cycle, done=1):
  - start=1: capture new operands, go RUN (back-to-back, no idle bubble).
  - Otherwise go IDLE.
  - done returns to 0 on the next edge in either case.
- Latency: start sampled at edge 0 → nibbles processed at edges 1..NIB → done high for the cycle after edge NIB. Throughput: one result per NIB+1 cycles back-to-back.
- busy=1 exactly while state==RUN; derived combinationally from the state register.
- start is ignored while in RUN; operands are not re-captured.
- abort:
  - In RUN: go IDLE at the next edge; sum/cout unchanged; no done pulse.
  - abort and final-nibble edge together: abort wins, no result is committed.
  - abort in IDLE/DONE: ignored.
- sum/cout change only on a committing edge; partial results are never visible on the outputs.
- Arithmetic is unsigned modulo 2^W; cout is the carry out of bit W-1.
- idx width is clog2(NIB); it never wraps past NIB-1 because the last-nibble edge exits RUN.
- Reset asserted mid-RUN: immediate return to the reset state; no done pulse.

Decomposition:
- Package serial_add_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t
  - localparam NIB_W = 4
- Sub-module nibble_add: combinational 4-bit adder with a, b, cin, sum[3:0], cout. Instantiated once; all sequencing stays in serial_add_ctrl.

Test Plan:
- W=16, a=0xFFFF, b=0x0001, cin=0, start pulse → busy high for 4 cycles; done in cycle 5; sum=0x0000, cout=1.
- a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Back-to-back: start held through DONE with second operands 0x8000+0x8000, cin=0 → first done, then a second done exactly 5 cycles later; sum=0x0000, cout=1; busy low only during DONE cycles.
- Start during RUN with different operands → ignored; the original result is committed; only one done pulse.
- abort asserted in the 3rd RUN cycle → IDLE next edge, no done; sum/cout keep prior values. Then abort coincident with the last nibble → again no commit.
- rst_n dropped asynchronously mid-RUN → all outputs 0 immediately. Then a random sweep of 1000 operations (W=16 and W=8) checked against a+b+cin, with zero mismatches required.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the nibble-serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - combinational 4-bit adder slice with carry in/out
import serial_add_pkg::*;

module nibble_add (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - W-bit a+b+cin computed one nibble per clock on a shared slice
import serial_add_pkg::*;

module serial_add_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int NIB   = W / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((W % NIB_W) != 0 || W < 8) begin : g_bad_width
        $error("serial_add_ctrl: W must be a multiple of 4 and at least 8");
    end

    sa_state_t          state;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [W-1:0]       work;
    logic [W-1:0]       merged;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [NIB_W-1:0]   s_sum;
    logic               s_cout;

    nibble_add u_slice (
        .a    (op_a[{idx, 2'b00} +: NIB_W]),
        .b    (op_b[{idx, 2'b00} +: NIB_W]),
        .cin  (carry_reg),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Working value with the current nibble folded in; on the last nibble this is the full sum.
    always_comb begin
        merged = work;
        merged[{idx, 2'b00} +: NIB_W] = s_sum;
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            work      <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a      <= a;
                        op_b      <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        work      <= merged;
                        carry_reg <= s_cout;
                        if (idx == IDX_W'(NIB - 1)) begin
                            sum   <= merged;
                            cout  <= s_cout;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, abort, cin;
    logic [15:0] a, b;
    logic        busy, done, cout;
    logic [15:0] sum;

    logic        start8, abort8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [16:0] last_res;

    serial_add_ctrl #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    function automatic logic [16:0] add16(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 17'(c);
    endfunction

    function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        #3;
        total_cnt++;
        if ({busy, done, cout, sum} !== 19'b0)
            $display("FAIL reset16: got %h expected 0", {busy, done, cout, sum});
        else pass_cnt++;
        total_cnt++;
        if ({busy8, done8, cout8, sum8} !== 11'b0)
            $display("FAIL reset8: got %h expected 0", {busy8, done8, cout8, sum8});
        else pass_cnt++;
        tick; tick;
        rst_n = 1'b1;
        tick;
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL idle_after_reset: got busy/done %b expected 00", {busy, done});
        else pass_cnt++;
        last_res = '0;
    endtask

    task automatic test_known;
        logic [15:0] ta [2];
        logic [15:0] tb_ [2];
        logic        tc [2];
        logic [16:0] exp;
        ta[0] = 16'hFFFF; tb_[0] = 16'h0001; tc[0] = 1'b0;
        ta[1] = 16'h1234; tb_[1] = 16'h4321; tc[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            exp = add16(ta[v], tb_[v], tc[v]);
            a = ta[v]; b = tb_[v]; cin = tc[v]; start = 1'b1;
            tick;
            start = 1'b0;
            total_cnt++;
            if ({busy, done, cout, sum} !== {2'b10, last_res})
                $display("FAIL known%0d_run0: got %h expected %h", v, {busy, done, cout, sum}, {2'b10, last_res});
            else pass_cnt++;
            for (int k = 1; k < 4; k++) begin
                tick;
                total_cnt++;
                if ({busy, done, cout, sum} !== {2'b10, last_res})
                    $display("FAIL known%0d_run%0d: got %h expected %h", v, k, {busy, done, cout, sum}, {2'b10, last_res});
                else pass_cnt++;
            end
            tick;
            total_cnt++;
            if ({busy, done, cout, sum} !== {2'b01, exp})
                $display("FAIL known%0d_done: got %h expected %h", v, {busy, done, cout, sum}, {2'b01, exp});
            else pass_cnt++;
            last_res = exp;
            tick;
            total_cnt++;
            if ({busy, done, cout, sum} !== {2'b00, last_res})
                $display("FAIL known%0d_hold: got %h expected %h", v, {busy, done, cout, sum}, {2'b00, last_res});
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [16:0] exp1, exp2;
        exp1 = add16(16'h1111, 16'h2222, 1'b1);
        exp2 = add16(16'h8000, 16'h8000, 1'b0);
        a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
        tick;
        a = 16'h8000; b = 16'h8000; cin = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick;
            total_cnt++;
            if ({busy, done, cout, sum} !== {2'b10, last_res})
                $display("FAIL b2b_run1_%0d: got %h expected %h", k, {busy, done, cout, sum}, {2'b10, last_res});
            else pass_cnt++;
        end
        tick;
        total_cnt++;
        if ({busy, done, cout, sum} !== {2'b01, exp1})
            $display("FAIL b2b_done1: got %h expected %h", {busy, done, cout, sum}, {2'b01, exp1});
        else pass_cnt++;
        last_res = exp1;
        tick;
        start = 1'b0;
        total_cnt++;
        if ({busy, done} !== 2'b10)
            $display("FAIL b2b_restart: got busy/done %b expected 10", {busy, done});
        else pass_cnt++;
        for (int k = 1; k < 4; k++) begin
            tick;
            total_cnt++;
            if ({busy, done, cout, sum} !== {2'b10, last_res})
                $display("FAIL b2b_run2_%0d: got %h expected %h", k, {busy, done, cout, sum}, {2'b10, last_res});
            else pass_cnt++;
        end
        tick;
        total_cnt++;
        if ({busy, done, cout, sum} !== {2'b01, exp2})
            $display("FAIL b2b_done2: got %h expected %h", {busy, done, cout, sum}, {2'b01, exp2});
        else pass_cnt++;
        last_res = exp2;
        tick;
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL b2b_idle: got busy/done %b expected 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_start_in_run;
        logic [16:0] exp;
        int          n_done;
        exp = add16(16'hABCD, 16'h0F0F, 1'b0);
        a = 16'hABCD; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        a = 16'h5555; b = 16'h3333; cin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        total_cnt++;
        if ({busy, done, cout, sum} !== {2'b01, exp})
            $display("FAIL startrun_done: got %h expected %h", {busy, done, cout, sum}, {2'b01, exp});
        else pass_cnt++;
        last_res = exp;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (done) n_done++;
        end
        total_cnt++;
        if (n_done !== 0 || busy !== 1'b0)
            $display("FAIL startrun_single: got extra done %0d busy %b expected 0 0", n_done, busy);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        int n_done;
        a = 16'($urandom); b = 16'($urandom); cin = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        total_cnt++;
        if ({busy, done, cout, sum} !== {2'b00, last_res})
            $display("FAIL abort_mid: got %h expected %h", {busy, done, cout, sum}, {2'b00, last_res});
        else pass_cnt++;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (done) n_done++;
        end
        total_cnt++;
        if (n_done !== 0)
            $display("FAIL abort_nodone: got %0d done pulses expected 0", n_done);
        else pass_cnt++;
        a = 16'h7777; b = 16'h1111; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        total_cnt++;
        if ({busy, done, cout, sum} !== {2'b00, last_res})
            $display("FAIL abort_last: got %h expected %h", {busy, done, cout, sum}, {2'b00, last_res});
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({done, cout, sum} !== {1'b0, last_res})
            $display("FAIL abort_last_hold: got %h expected %h", {done, cout, sum}, {1'b0, last_res});
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        a = 16'h4321; b = 16'h0101; cin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, cout, sum} !== 19'b0)
            $display("FAIL async_reset: got %h expected 0", {busy, done, cout, sum});
        else pass_cnt++;
        tick;
        total_cnt++;
        if ({busy, done, cout, sum} !== 19'b0)
            $display("FAIL async_reset_held: got %h expected 0", {busy, done, cout, sum});
        else pass_cnt++;
        rst_n = 1'b1;
        last_res = '0;
        tick;
    endtask

    task automatic test_sweep16;
        logic [16:0] exp;
        int          cyc;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
            exp = add16(a, b, cin);
            start = 1'b1;
            tick;
            start = 1'b0;
            cyc = 0;
            while (done !== 1'b1 && cyc < 12) begin
                tick;
                cyc++;
            end
            total_cnt++;
            if (cyc !== 4)
                $display("FAIL sweep16_latency op %0d: got %0d cycles expected 4", i, cyc);
            else pass_cnt++;
            total_cnt++;
            if ({cout, sum} !== exp)
                $display("FAIL sweep16_result op %0d: got %h expected %h", i, {cout, sum}, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_sweep8;
        logic [8:0] exp;
        int         cyc;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
            exp = add8(a8, b8, cin8);
            start8 = 1'b1;
            tick;
            start8 = 1'b0;
            cyc = 0;
            while (done8 !== 1'b1 && cyc < 12) begin
                tick;
                cyc++;
            end
            total_cnt++;
            if (cyc !== 2)
                $display("FAIL sweep8_latency op %0d: got %0d cycles expected 2", i, cyc);
            else pass_cnt++;
            total_cnt++;
            if ({cout8, sum8} !== exp)
                $display("FAIL sweep8_result op %0d: got %h expected %h", i, {cout8, sum8}, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_known;
        test_back_to_back;
        test_start_in_run;
        test_abort;
        test_async_reset;
        test_sweep16;
        test_sweep8;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
